// File: rtl/bidir_count_monitor.sv
// bidir_count_monitor: checks each sample of an up/down counter is exactly +1/-1 from the last one and keeps saturating statistics.
// Optional: define MON_DIRCHG_EN to count direction changes on dir_chg_cnt (tied to 0 otherwise).
module bidir_count_monitor #(
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          en,
  input  logic          clr_stats,
  input  logic [W-1:0]  q_in,
  input  logic          mode_in,
  output logic          err_pulse,
  output logic          err_sticky,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] up_wraps,
  output logic [CW-1:0] down_wraps,
  output logic [CW-1:0] dir_chg_cnt,
  output logic          locked
);
  typedef enum logic {SYNC, TRACK} state_t;
  state_t        r_state, w_next;
  logic [W-1:0]  r_prev_q, w_exp;
  logic          r_prev_mode, r_err_pulse, r_err_sticky;
  logic [CW-1:0] r_err_cnt, r_up_wraps, r_down_wraps;
  logic          w_check, w_match, w_mismatch, w_up_inc, w_down_inc;
  function automatic logic [CW-1:0] bump(input logic [CW-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + CW'(1) : c;
  endfunction
  always_comb begin
    w_exp      = r_prev_mode ? r_prev_q + W'(1) : r_prev_q - W'(1);
    w_check    = (r_state == TRACK) && en;
    w_match    = w_check && (q_in == w_exp);
    w_mismatch = w_check && (q_in != w_exp);
    w_up_inc   = w_match && r_prev_mode && (&r_prev_q);
    w_down_inc = w_match && !r_prev_mode && (r_prev_q == '0);
    w_next     = (r_state == SYNC) ? (en ? TRACK : SYNC) : (w_match ? TRACK : SYNC);
  end
  // The current sample always becomes the reference, including a mismatching one.
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      r_state      <= SYNC;
      r_prev_q     <= '0;
      r_prev_mode  <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_up_wraps   <= '0;
      r_down_wraps <= '0;
    end else begin
      r_state      <= w_next;
      r_prev_q     <= q_in;
      r_prev_mode  <= mode_in;
      r_err_pulse  <= w_mismatch;
      r_err_sticky <= clr_stats ? 1'b0 : (r_err_sticky | w_mismatch);
      r_err_cnt    <= clr_stats ? '0 : bump(r_err_cnt, w_mismatch);
      r_up_wraps   <= clr_stats ? '0 : bump(r_up_wraps, w_up_inc);
      r_down_wraps <= clr_stats ? '0 : bump(r_down_wraps, w_down_inc);
    end
`ifdef MON_DIRCHG_EN
  logic [CW-1:0] r_dir_chg;
  logic          w_dir_inc;
  assign w_dir_inc = w_match && (mode_in != r_prev_mode);
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) r_dir_chg <= '0;
    else      r_dir_chg <= clr_stats ? '0 : bump(r_dir_chg, w_dir_inc);
  assign dir_chg_cnt = r_dir_chg;
`else
  assign dir_chg_cnt = '0;
`endif
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;
  assign up_wraps   = r_up_wraps;
  assign down_wraps = r_down_wraps;
  assign locked     = (r_state == TRACK);
endmodule

// File: tb/tb_bidir_count_monitor.sv
// tb_bidir_count_monitor: directed vectors for bidir_count_monitor (CW=8 main instance, CW=2 saturation instance).
module tb_bidir_count_monitor;
`ifdef MON_DIRCHG_EN
  localparam int EXP_DIR = 1;
`else
  localparam int EXP_DIR = 0;
`endif
  logic       CLK, CLR, en, clr_stats, mode;
  logic [2:0] q;
  logic       err_pulse, err_sticky, locked;
  logic [7:0] err_cnt, up_wraps, down_wraps, dir_chg_cnt;
  logic       err_pulse2, err_sticky2, locked2;
  logic [1:0] err_cnt2, up_wraps2, down_wraps2, dir_chg_cnt2;
  int         n_vec = 0, n_err = 0;
  bidir_count_monitor #(.W(3), .CW(8)) dut (
    .CLK(CLK), .CLR(CLR), .en(en), .clr_stats(clr_stats), .q_in(q), .mode_in(mode),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_cnt(err_cnt), .up_wraps(up_wraps),
    .down_wraps(down_wraps), .dir_chg_cnt(dir_chg_cnt), .locked(locked)
  );
  bidir_count_monitor #(.W(3), .CW(2)) dut_sat (
    .CLK(CLK), .CLR(CLR), .en(en), .clr_stats(clr_stats), .q_in(q), .mode_in(mode),
    .err_pulse(err_pulse2), .err_sticky(err_sticky2), .err_cnt(err_cnt2), .up_wraps(up_wraps2),
    .down_wraps(down_wraps2), .dir_chg_cnt(dir_chg_cnt2), .locked(locked2)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic [2:0] qv, input logic m);
    q = qv;
    mode = m;
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    CLR = 1'b0;
    en = 1'b0;
    clr_stats = 1'b0;
    q = '0;
    mode = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b1;
    en = 1'b1;
  endtask
  initial begin
    logic [2:0] v;
    do_reset();
    chk("rst_pulse", err_pulse, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_up", up_wraps, 0);
    chk("rst_down", down_wraps, 0);
    chk("rst_dir", dir_chg_cnt, 0);
    chk("rst_locked", locked, 0);
    // test 1: up count 0..19
    step(3'd0, 1'b1);
    step(3'd1, 1'b1);
    chk("t1_locked_e2", locked, 1);
    for (int i = 2; i < 20; i++) step(3'(i), 1'b1);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_sticky", err_sticky, 0);
    chk("t1_up", up_wraps, 2);
    chk("t1_down", down_wraps, 0);
    chk("t1_locked", locked, 1);
    // test 2: down count from 0 for 10 edges
    do_reset();
    v = 3'd0;
    for (int i = 0; i < 10; i++) begin
      step(v, 1'b0);
      v = v - 3'd1;
    end
    chk("t2_down", down_wraps, 2);
    chk("t2_up", up_wraps, 0);
    chk("t2_err_cnt", err_cnt, 0);
    // test 3: jump 3 -> 6
    do_reset();
    for (int i = 0; i < 4; i++) step(3'(i), 1'b1);
    chk("t3_pre_pulse", err_pulse, 0);
    step(3'd6, 1'b1);
    chk("t3_pulse", err_pulse, 1);
    chk("t3_sticky", err_sticky, 1);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_unlocked", locked, 0);
    step(3'd7, 1'b1);
    chk("t3_pulse_end", err_pulse, 0);
    chk("t3_relock", locked, 1);
    step(3'd0, 1'b1);
    step(3'd1, 1'b1);
    step(3'd2, 1'b1);
    chk("t3_err_after", err_cnt, 1);
    chk("t3_up", up_wraps, 1);
    chk("t3_sticky_hold", err_sticky, 1);
    // test 4: up 0..4 then down to 1
    do_reset();
    for (int i = 0; i < 4; i++) step(3'(i), 1'b1);
    step(3'd4, 1'b0);
    step(3'd3, 1'b0);
    step(3'd2, 1'b0);
    step(3'd1, 1'b0);
    chk("t4_dir", dir_chg_cnt, EXP_DIR);
    chk("t4_err_cnt", err_cnt, 0);
    chk("t4_locked", locked, 1);
    // test 5: error on the same edge as clr_stats
    clr_stats = 1'b1;
    step(3'd5, 1'b0);
    clr_stats = 1'b0;
    chk("t5_pulse", err_pulse, 1);
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_sticky", err_sticky, 0);
    chk("t5_dir_clr", dir_chg_cnt, 0);
    chk("t5_unlocked", locked, 0);
    step(3'd5, 1'b1);
    step(3'd6, 1'b1);
    chk("t5_pulse_end", err_pulse, 0);
    step(3'd7, 1'b1);
    for (int i = 0; i < 6; i++) step(3'(i), 1'b1);
    chk("t5_up", up_wraps, 1);
    chk("t5_err_cnt2", err_cnt, 0);
    #2;
    CLR = 1'b0;
    #1;
    chk("t5_clr_up", up_wraps, 0);
    chk("t5_clr_locked", locked, 0);
    chk("t5_clr_sat_up", up_wraps2, 0);
    CLR = 1'b1;
    step(3'd0, 1'b1);
    chk("t5_rel_pulse", err_pulse, 0);
    step(3'd1, 1'b1);
    step(3'd2, 1'b1);
    chk("t5_rel_err", err_cnt, 0);
    chk("t5_rel_locked", locked, 1);
    // test 6: held value gives an error every second edge
    do_reset();
    for (int i = 0; i < 11; i++) step(3'd0, 1'b1);
    chk("t6_err_cnt", err_cnt, 5);
    chk("t6_sat_err_cnt", err_cnt2, 3);
    chk("t6_sat_sticky", err_sticky2, 1);
    clr_stats = 1'b1;
    step(3'd0, 1'b1);
    clr_stats = 1'b0;
    chk("t6_clr_sat", err_cnt2, 0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      chk("t6_en0_pulse", err_pulse, 0);
      chk("t6_en0_locked", locked, 0);
    end
    chk("t6_en0_err_cnt", err_cnt, 0);
    chk("t6_en0_sat_err", err_cnt2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
